// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timekeeping slice.
// Holds the state encoding, BCD digit types and the digit step helper.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_LAP   = 2'd2,
        ST_PAUSE = 2'd3
    } state_e;

    localparam int DIGIT_W   = 4;
    localparam int SEC_T_MAX = 5;
    localparam int DIGIT_MAX = 9;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef struct packed {
        digit_t min_t;
        digit_t min_u;
        digit_t sec_t;
        digit_t sec_u;
        digit_t cs_t;
        digit_t cs_u;
    } bcd_time_t;

    // Next value of a single BCD digit that rolls over to 0 after max.
    function automatic digit_t digit_next(input digit_t q, input logic inc, input digit_t max);
        if (!inc)
            return q;
        if (q == max)
            return '0;
        return q + digit_t'(1);
    endfunction

endpackage

// File: rtl/stopwatch_bcd_digit_counter.sv
// One BCD digit of the elapsed-time cascade; counts 0..MAX and rolls over.
// carry is combinational so the whole cascade advances on a single edge.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX = DIGIT_MAX
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    output logic [DIGIT_W-1:0] q,
    output logic               carry
);

    localparam digit_t LIM = digit_t'(MAX);

    // NOTE: state registers use non-blocking assignments so every digit samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else
            q <= digit_next(q, inc, LIM);
    end

    assign carry = inc && (q == LIM);

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch timekeeping core: run/stop/lap/clear control over a BCD MM:SS.CC
// cascade, with a registered display that freezes while in LAP.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int TICKS_PER_CS = 10,
    parameter int MAX_MIN      = 59
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_tick,
    input  logic                 i_start_stop,
    input  logic                 i_lap,
    input  logic                 i_clear,
    output logic [DIGIT_W-1:0]   o_min_t,
    output logic [DIGIT_W-1:0]   o_min_u,
    output logic [DIGIT_W-1:0]   o_sec_t,
    output logic [DIGIT_W-1:0]   o_sec_u,
    output logic [DIGIT_W-1:0]   o_cs_t,
    output logic [DIGIT_W-1:0]   o_cs_u,
    output logic [1:0]           o_state,
    output logic                 o_wrap
);

    localparam digit_t     MIN_T_LIM = digit_t'(MAX_MIN / 10);
    localparam digit_t     MIN_U_LIM = digit_t'(MAX_MIN % 10);
    localparam digit_t     D_MAX     = digit_t'(DIGIT_MAX);
    localparam digit_t     S_MAX     = digit_t'(SEC_T_MAX);
    localparam logic [7:0] PRE_LAST  = 8'(TICKS_PER_CS - 1);

    state_e    state, next_state;
    logic [7:0] presc;
    logic      counted, cs_step, wrap_now, min_clr;
    logic      inc_cs_t, inc_sec_u, inc_sec_t, inc_min_u, inc_min_t, carry_min_t;
    digit_t    q_min_t, q_min_u, q_sec_t, q_sec_u, q_cs_t, q_cs_u;
    bcd_time_t live, live_next, disp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        if (i_clear) begin
            next_state = ST_IDLE;
        end else if (i_start_stop) begin
            unique case (state)
                ST_IDLE, ST_PAUSE: next_state = ST_RUN;
                ST_RUN, ST_LAP:    next_state = ST_PAUSE;
            endcase
        end else if (i_lap) begin
            if (state == ST_RUN)
                next_state = ST_LAP;
            else if (state == ST_LAP)
                next_state = ST_RUN;
        end
    end

    assign counted = i_tick && !i_clear && (state == ST_RUN || state == ST_LAP);
    assign cs_step = counted && (presc == PRE_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            presc <= '0;
        else if (i_clear)
            presc <= '0;
        else if (counted)
            presc <= cs_step ? '0 : presc + 8'd1;
    end

    bcd_digit_counter #(.MAX(DIGIT_MAX)) u_cs_u (
        .clk(clk), .rst(rst), .clr(i_clear), .inc(cs_step),   .q(q_cs_u),  .carry(inc_cs_t));
    bcd_digit_counter #(.MAX(DIGIT_MAX)) u_cs_t (
        .clk(clk), .rst(rst), .clr(i_clear), .inc(inc_cs_t),  .q(q_cs_t),  .carry(inc_sec_u));
    bcd_digit_counter #(.MAX(DIGIT_MAX)) u_sec_u (
        .clk(clk), .rst(rst), .clr(i_clear), .inc(inc_sec_u), .q(q_sec_u), .carry(inc_sec_t));
    bcd_digit_counter #(.MAX(SEC_T_MAX)) u_sec_t (
        .clk(clk), .rst(rst), .clr(i_clear), .inc(inc_sec_t), .q(q_sec_t), .carry(inc_min_u));
    bcd_digit_counter #(.MAX(DIGIT_MAX)) u_min_u (
        .clk(clk), .rst(rst), .clr(min_clr), .inc(inc_min_u), .q(q_min_u), .carry(inc_min_t));
    bcd_digit_counter #(.MAX(DIGIT_MAX)) u_min_t (
        .clk(clk), .rst(rst), .clr(min_clr), .inc(inc_min_t), .q(q_min_t), .carry(carry_min_t));

    assign live = '{min_t: q_min_t, min_u: q_min_u, sec_t: q_sec_t,
                    sec_u: q_sec_u, cs_t: q_cs_t, cs_u: q_cs_u};

    // The minute-tens carry only fires at 99:59.99, which is the wrap point when MAX_MIN is 99.
    assign wrap_now = (inc_min_u && live.min_t == MIN_T_LIM && live.min_u == MIN_U_LIM)
                   || carry_min_t;
    assign min_clr  = i_clear || wrap_now;

    always_comb begin
        live_next       = live;
        live_next.cs_u  = i_clear ? '0 : digit_next(live.cs_u,  cs_step,   D_MAX);
        live_next.cs_t  = i_clear ? '0 : digit_next(live.cs_t,  inc_cs_t,  D_MAX);
        live_next.sec_u = i_clear ? '0 : digit_next(live.sec_u, inc_sec_u, D_MAX);
        live_next.sec_t = i_clear ? '0 : digit_next(live.sec_t, inc_sec_t, S_MAX);
        live_next.min_u = min_clr ? '0 : digit_next(live.min_u, inc_min_u, D_MAX);
        live_next.min_t = min_clr ? '0 : digit_next(live.min_t, inc_min_t, D_MAX);
    end

    // Outside LAP the display tracks the live time edge-for-edge, so holding it on
    // entry to LAP captures exactly the live time of that edge: it is the lap snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            disp <= '0;
        else if (next_state != ST_LAP)
            disp <= live_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            o_wrap <= 1'b0;
        else
            o_wrap <= wrap_now;
    end

    assign o_min_t = disp.min_t;
    assign o_min_u = disp.min_u;
    assign o_sec_t = disp.sec_t;
    assign o_sec_u = disp.sec_u;
    assign o_cs_t  = disp.cs_t;
    assign o_cs_u  = disp.cs_u;
    assign o_state = state;

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core: a vector table, directed corner sequences
// and randomized traffic against a total-ticks arithmetic model.
module tb_stopwatch_core;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Main unit: TICKS_PER_CS=10, MAX_MIN=59
    logic       tick = 0, ss = 0, lap = 0, clr = 0;
    logic [3:0] m_min_t, m_min_u, m_sec_t, m_sec_u, m_cs_t, m_cs_u;
    logic [1:0] m_state;
    logic       m_wrap;

    // Fast-wrap unit: TICKS_PER_CS=1, MAX_MIN=1
    logic       w_tick = 0, w_ss = 0, w_lap = 0, w_clr = 0;
    logic [3:0] w_min_t, w_min_u, w_sec_t, w_sec_u, w_cs_t, w_cs_u;
    logic [1:0] w_state;
    logic       w_wrap;

    stopwatch_core #(.TICKS_PER_CS(10), .MAX_MIN(59)) dut (
        .clk(clk), .rst(rst), .i_tick(tick), .i_start_stop(ss), .i_lap(lap), .i_clear(clr),
        .o_min_t(m_min_t), .o_min_u(m_min_u), .o_sec_t(m_sec_t), .o_sec_u(m_sec_u),
        .o_cs_t(m_cs_t), .o_cs_u(m_cs_u), .o_state(m_state), .o_wrap(m_wrap));

    stopwatch_core #(.TICKS_PER_CS(1), .MAX_MIN(1)) dut_w (
        .clk(clk), .rst(rst), .i_tick(w_tick), .i_start_stop(w_ss), .i_lap(w_lap), .i_clear(w_clr),
        .o_min_t(w_min_t), .o_min_u(w_min_u), .o_sec_t(w_sec_t), .o_sec_u(w_sec_u),
        .o_cs_t(w_cs_t), .o_cs_u(w_cs_u), .o_state(w_state), .o_wrap(w_wrap));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       t, s, l, c;
        int         cs;
        logic [1:0] st;
    } vec_t;

    vec_t vecs[20];

    // Expected observation: {state, wrap, six BCD digits} from a centisecond count.
    function automatic logic [26:0] expect_obs(input int cs, input logic [1:0] st, input logic wr);
        int mins, secs, c;
        mins = cs / 6000;
        secs = (cs / 100) % 60;
        c    = cs % 100;
        return {st, wr, 4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10),
                4'(c / 10), 4'(c % 10)};
    endfunction

    function automatic logic [26:0] obs_m();
        return {m_state, m_wrap, m_min_t, m_min_u, m_sec_t, m_sec_u, m_cs_t, m_cs_u};
    endfunction

    function automatic logic [26:0] obs_w();
        return {w_state, w_wrap, w_min_t, w_min_u, w_sec_t, w_sec_u, w_cs_t, w_cs_u};
    endfunction

    task automatic check(input string name, input logic [26:0] got, input logic [26:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got state=%0d wrap=%0d time=%h, expected state=%0d wrap=%0d time=%h",
                     name, got[26:25], got[24], got[23:0], exp[26:25], exp[24], exp[23:0]);
        end
    endtask

    task automatic m_cycle(input logic t, input logic s, input logic l, input logic c);
        tick = t; ss = s; lap = l; clr = c;
        @(posedge clk);
        #1;
        tick = 0; ss = 0; lap = 0; clr = 0;
    endtask

    task automatic m_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            m_cycle(1, 0, 0, 0);
            m_cycle(0, 0, 0, 0);
        end
    endtask

    task automatic w_cycle(input logic t, input logic s, input logic l, input logic c);
        w_tick = t; w_ss = s; w_lap = l; w_clr = c;
        @(posedge clk);
        #1;
        w_tick = 0; w_ss = 0; w_lap = 0; w_clr = 0;
    endtask

    // Reference model: mode, counted ticks since clear (mod one full wrap period), frozen lap time.
    localparam int M_T      = 10;
    localparam int M_PERIOD = M_T * 60 * 6000;
    int   md  = 0;
    int   tk  = 0;
    int   frz = 0;
    logic mwr = 0;

    task automatic model_step(input logic t, input logic s, input logic l, input logic c);
        int nm;
        mwr = 0;
        if (c) begin
            md = 0; tk = 0; frz = 0;
        end else begin
            nm = md;
            if (s)
                nm = (md == 0 || md == 3) ? 1 : 3;
            else if (l && md == 1) begin
                nm  = 2;
                frz = tk / M_T;
            end else if (l && md == 2)
                nm = 1;
            if (t && (md == 1 || md == 2)) begin
                tk++;
                if (tk == M_PERIOD) begin
                    tk  = 0;
                    mwr = 1;
                end
            end
            md = nm;
        end
    endtask

    function automatic int model_disp();
        return (md == 2) ? frz : tk / M_T;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{0, 1, 0, 0, 0, 2'd1};  // start from IDLE
        vecs[1]  = '{1, 0, 0, 0, 1, 2'd1};
        vecs[2]  = '{0, 0, 0, 0, 1, 2'd1};
        vecs[3]  = '{1, 0, 0, 0, 2, 2'd1};
        vecs[4]  = '{0, 0, 1, 0, 2, 2'd2};  // lap freezes
        vecs[5]  = '{1, 0, 0, 0, 2, 2'd2};
        vecs[6]  = '{1, 0, 0, 0, 2, 2'd2};
        vecs[7]  = '{0, 0, 1, 0, 4, 2'd1};  // release shows live
        vecs[8]  = '{1, 1, 0, 0, 5, 2'd3};  // stop tick is counted
        vecs[9]  = '{1, 0, 0, 0, 5, 2'd3};
        vecs[10] = '{0, 0, 1, 0, 5, 2'd3};  // lap ignored in PAUSE
        vecs[11] = '{1, 1, 0, 0, 5, 2'd1};  // resume tick not counted
        vecs[12] = '{1, 0, 0, 0, 6, 2'd1};
        vecs[13] = '{1, 0, 0, 1, 0, 2'd0};  // clear discards tick
        vecs[14] = '{0, 0, 1, 0, 0, 2'd0};  // lap ignored in IDLE
        vecs[15] = '{1, 0, 0, 0, 0, 2'd0};
        vecs[16] = '{1, 1, 0, 0, 0, 2'd1};  // start tick not counted
        vecs[17] = '{0, 1, 0, 1, 0, 2'd0};  // clear beats start_stop
        vecs[18] = '{0, 1, 0, 0, 0, 2'd1};
        vecs[19] = '{0, 1, 1, 0, 0, 2'd3};  // start_stop beats lap

        repeat (2) @(posedge clk);
        #1;
        check("reset_main", obs_m(), expect_obs(0, 2'd0, 0));
        check("reset_wrapunit", obs_w(), expect_obs(0, 2'd0, 0));
        rst = 0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++) begin
            w_cycle(vecs[i].t, vecs[i].s, vecs[i].l, vecs[i].c);
            check($sformatf("vec%0d", i), obs_w(), expect_obs(vecs[i].cs, vecs[i].st, 0));
            w_cycle(0, 0, 0, 0);
        end

        // Basic count
        m_cycle(0, 1, 0, 0);
        m_ticks(999);
        check("count_999", obs_m(), expect_obs(99, 2'd1, 0));
        m_ticks(1);
        check("count_1000", obs_m(), expect_obs(100, 2'd1, 0));

        // Reset mid-run at 00:01.23
        m_ticks(230);
        check("run_1_23", obs_m(), expect_obs(123, 2'd1, 0));
        rst = 1;
        #2;
        check("reset_midrun", obs_m(), expect_obs(0, 2'd0, 0));
        @(posedge clk);
        #1;
        rst = 0;
        check("reset_release", obs_m(), expect_obs(0, 2'd0, 0));

        // Pause/resume keeps the sub-centisecond remainder
        m_cycle(0, 1, 0, 0);
        m_ticks(15);
        m_cycle(0, 1, 0, 0);
        m_ticks(50);
        check("paused", obs_m(), expect_obs(1, 2'd3, 0));
        m_cycle(0, 1, 0, 0);
        m_ticks(5);
        check("pause_resume", obs_m(), expect_obs(2, 2'd1, 0));

        // Lap freeze and release
        m_cycle(0, 0, 0, 1);
        check("clear", obs_m(), expect_obs(0, 2'd0, 0));
        m_cycle(0, 1, 0, 0);
        m_ticks(500);
        m_cycle(0, 0, 1, 0);
        check("lap_freeze", obs_m(), expect_obs(50, 2'd2, 0));
        m_ticks(300);
        check("lap_hold", obs_m(), expect_obs(50, 2'd2, 0));
        m_cycle(0, 0, 1, 0);
        check("lap_release", obs_m(), expect_obs(80, 2'd1, 0));

        // Simultaneous events
        m_cycle(1, 1, 0, 1);
        check("clr_ss_tick", obs_m(), expect_obs(0, 2'd0, 0));
        m_cycle(0, 0, 0, 0);
        m_cycle(1, 1, 0, 0);
        check("start_tick", obs_m(), expect_obs(0, 2'd1, 0));
        m_cycle(0, 0, 0, 0);
        m_ticks(9);
        check("presc_zero_9", obs_m(), expect_obs(0, 2'd1, 0));
        m_ticks(1);
        check("presc_zero_10", obs_m(), expect_obs(1, 2'd1, 0));

        // Wrap on the fast unit: 01:59.99 -> 00:00.00
        w_cycle(0, 0, 0, 1);
        w_cycle(0, 1, 0, 0);
        for (int i = 0; i < 11999; i++) begin
            w_cycle(1, 0, 0, 0);
            w_cycle(0, 0, 0, 0);
        end
        check("pre_wrap", obs_w(), expect_obs(11999, 2'd1, 0));
        w_cycle(1, 0, 0, 0);
        check("wrap_edge", obs_w(), expect_obs(0, 2'd1, 1));
        w_cycle(0, 0, 0, 0);
        check("wrap_one_cycle", obs_w(), expect_obs(0, 2'd1, 0));
        w_cycle(1, 0, 0, 0);
        check("post_wrap", obs_w(), expect_obs(1, 2'd1, 0));

        // Randomized traffic against the model
        m_cycle(0, 0, 0, 1);
        md = 0; tk = 0; frz = 0;
        begin
            logic pt, t, s, l, c;
            pt = 0;
            for (int i = 0; i < 4000; i++) begin
                t = !pt && ($urandom_range(1, 0) == 1);
                s = ($urandom_range(24, 0) == 0);
                l = !t && ($urandom_range(9, 0) == 0);
                c = ($urandom_range(199, 0) == 0);
                model_step(t, s, l, c);
                m_cycle(t, s, l, c);
                check($sformatf("rand%0d", i), obs_m(), expect_obs(model_disp(), 2'(md), mwr));
                pt = t;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
- Timekeeping stage that consumes the 1 kHz single-cycle tick from the clock divider.
- Accumulates elapsed time as BCD MM:SS.CC (minutes, seconds, centiseconds).
- Start/stop, lap-freeze and clear controls.
- Feeds the display/LCD formatting stage with registered BCD digits and a status state.

Parameters:
- TICKS_PER_CS, 10, input ticks per centisecond; legal range 1..255.
- MAX_MIN, 59, highest minute value before wrap; legal range 1..99.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- i_tick  input  1  1-cycle pulse, nominally one per ms; never high two consecutive cycles
- i_start_stop  input  1  1-cycle pulse (already debounced); toggles run/stop
- i_lap  input  1  1-cycle pulse; freezes/releases the displayed time
- i_clear  input  1  1-cycle pulse; zeroes time, returns to IDLE
- o_min_t  output  4  displayed minutes tens, BCD
- o_min_u  output  4  displayed minutes units, BCD
- o_sec_t  output  4  displayed seconds tens, 0..5
- o_sec_u  output  4  displayed seconds units
- o_cs_t  output  4  displayed centiseconds tens
- o_cs_u  output  4  displayed centiseconds units
- o_state  output  2  0=IDLE, 1=RUN, 2=LAP, 3=PAUSE
- o_wrap  output  1  1-cycle pulse when time rolls MAX_MIN:59.99 -> 00:00.00

Behaviour:
- Reset (async): all digits 0, o_state=IDLE, o_wrap=0, prescaler=0, lap snapshot=0.
- State machine. Inputs are evaluated per cycle with priority clear > start_stop > lap.
  - IDLE: start_stop -> RUN. lap is ignored.
  - RUN: start_stop -> PAUSE. lap -> LAP (snapshot the live time in the same edge).
  - LAP: counting continues. lap -> RUN (display live again). start_stop -> PAUSE (display live).
  - PAUSE: start_stop -> RUN, resuming from the held time. lap is ignored.
  - Any state: clear -> IDLE. Live time, snapshot and prescaler are zeroed, o_wrap=0.
- Counting:
  - A tick is counted only when the registered state is RUN or LAP in that cycle.
  - A tick in the same cycle as start_stop from IDLE/PAUSE is not counted.
  - A tick in the same cycle as stop from RUN is counted.
  - A tick in the same cycle as clear is discarded.
- Prescaler counts counted ticks 0..TICKS_PER_CS-1. On reaching TICKS_PER_CS-1 with a counted tick, it returns to 0 and the centisecond counter advances.
- Cascade: cs_u 0-9 -> cs_t 0-9 -> sec_u 0-9 -> sec_t 0-5 -> minutes 00..MAX_MIN.
  - All digits update on the same clock edge; no intermediate values are ever visible.
- Wrap: at MAX_MIN:59.99 plus one centisecond, all digits become 0 and o_wrap pulses for exactly 1 cycle. Counting continues.
- Latency: output digits change on the clock edge that samples the qualifying tick, so they are valid the following cycle.
- Display mux:
  - LAP state: outputs show the snapshot.
  - Otherwise: outputs show the live time.
  - The mux is registered, and the output changes on the same edge as the state change.
- PAUSE holds the prescaler value; the sub-centisecond remainder is preserved on resume.
- Digits are always valid BCD; no value above 9 (above 5 for sec_t) ever appears.
- Unused minute encodings are unreachable; MAX_MIN tens/units are derived at elaboration.

Decomposition:
- Package stopwatch_pkg:
  - state encoding (IDLE/RUN/LAP/PAUSE, 2 bits)
  - BCD digit width (4)
  - constants SEC_T_MAX=5, DIGIT_MAX=9
- Sub-module bcd_digit_counter, instantiated once per digit:
  - Parameters: MAX.
  - Inputs: clk, rst, clr, inc.
  - Outputs: q[3:0], carry. carry is combinational: inc && q==MAX.
  - On inc at MAX, q returns to 0.
- Minutes are two bcd_digit_counter instances plus a compare against MAX_MIN for the wrap.

Test Plan:
- Reset mid-run. Run to 00:01.23, assert rst for 1 cycle -> all digits 0, o_state=0 the cycle after rst rises.
- Basic count (TICKS_PER_CS=10). start_stop, then 1000 ticks -> display 00:01.00 and o_state=1; 999 ticks -> 00:00.99.
- Pause/resume. Run 15 ticks, stop, apply 50 ticks, start, 5 more ticks -> display 00:00.02; the paused ticks are not counted.
- Lap.
  - Run to 00:00.50, pulse lap -> display frozen at 00:00.50, o_state=2.
  - 300 more ticks -> display still 00:00.50.
  - Lap again -> display 00:00.80.
- Wrap (MAX_MIN=1 for speed). Run to 01:59.99, then 10 ticks -> 00:00.00 and o_wrap high for exactly 1 cycle.
- Simultaneous events.
  - clear+start_stop+tick in one cycle while running -> IDLE, all 0.
  - tick in the same cycle as start from IDLE -> still 00:00.00 with prescaler 0.
